// File: rtl/inc_share_arbiter.sv
// Two-requester round-robin arbiter sharing a single pipelined incrementor.
// Accept in cycle N returns doneX/result/carryOut in cycle N+2.
module inc_share_arbiter #(
  parameter int unsigned SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic [SIZE-1:0] in0,
  input  logic            req1,
  input  logic [SIZE-1:0] in1,
  output logic            ack0,
  output logic            ack1,
  output logic            done0,
  output logic            done1,
  output logic [SIZE-1:0] result,
  output logic            carryOut
);

  localparam int unsigned NumCells = SIZE / 2;

  logic            last_grant_q;
  logic            vld_q;
  logic            id_q;
  logic [SIZE-1:0] op_q;
  logic            done0_q, done1_q;
  logic [SIZE-1:0] result_q;
  logic            carry_q;

  logic [SIZE-1:0]   sum;
  logic [NumCells:0] carry;
  logic              accept;

  // last_grant_q == 1 means requester 1 won most recently, so requester 0 wins a tie
  always_comb begin
    ack0 = 1'b0;
    ack1 = 1'b0;
    if (!rst) begin
      if (req0 && (!req1 || last_grant_q)) begin
        ack0 = 1'b1;
      end else if (req1) begin
        ack1 = 1'b1;
      end
    end
  end

  assign accept = ack0 | ack1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      vld_q        <= 1'b0;
      id_q         <= 1'b0;
      op_q         <= '0;
    end else begin
      vld_q <= accept;
      if (accept) begin
        op_q         <= ack1 ? in1 : in0;
        id_q         <= ack1;
        last_grant_q <= ack1;
      end
    end
  end

  // Shared incrementor: ripple of 2-bit half-adder cells, carry-in tied high
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < NumCells; g++) begin : g_cell
    logic mid;
    assign sum[2*g]     = op_q[2*g] ^ carry[g];
    assign mid          = op_q[2*g] & carry[g];
    assign sum[2*g+1]   = op_q[2*g+1] ^ mid;
    assign carry[g+1]   = op_q[2*g+1] & mid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      done0_q <= vld_q & ~id_q;
      done1_q <= vld_q & id_q;
      if (vld_q) begin
        result_q <= sum;
        carry_q  <= carry[NumCells];
      end
    end
  end

  assign done0    = done0_q;
  assign done1    = done1_q;
  assign result   = result_q;
  assign carryOut = carry_q;

endmodule
